// File: rtl/led_pkg.sv
// led_fader shared types and defaults.
// Imported by the fader top, its channel slice and its interface.
package led_pkg;

   localparam int NLEDS_DEFAULT     = 7;
   localparam int BW_DEFAULT        = 4;
   localparam int DECAY_DIV_DEFAULT = 2 ** 18;

   typedef logic [BW_DEFAULT-1:0] bright_t;

   // Width of a counter that runs 0..div-1; never zero.
   function automatic int cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/led_fader_if.sv
// Pattern-in / PWM-out bundle of the LED fader.
// master drives the raw pattern, slave returns the LED drive.
interface led_fader_if
   import led_pkg::*;
#(
   parameter int NLEDS = NLEDS_DEFAULT
);

   logic [NLEDS-1:0] led;
   logic [NLEDS-1:0] o_led;
   logic             active;

   modport master (
      output led,
      input  o_led,
      input  active
   );

   modport slave (
      input  led,
      output o_led,
      output active
   );

endinterface

// File: rtl/led_fade_channel.sv
// One LED afterglow slice: brightness register plus PWM compare.
// Loading full brightness wins over a decay tick in the same cycle.
module led_fade_channel
   import led_pkg::*;
#(
   parameter int BW = BW_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_led_bit,
   input  logic          i_tick,
   input  logic [BW-1:0] i_pwm_cnt,
   output logic          o_led_bit,
   output logic          o_nonzero
);

   localparam logic [BW-1:0] MAX = '1;

   logic [BW-1:0] bright;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bright    <= '0;
         o_led_bit <= 1'b0;
      end else begin
         if (i_led_bit)
            bright <= MAX;
         else if (i_tick && bright != '0)
            bright <= bright - BW'(1);
         o_led_bit <= bright > i_pwm_cnt;
      end
   end

   assign o_nonzero = |bright;

endmodule

// File: rtl/led_fader.sv
// Afterglow stage behind the LED walker: per-LED linear fade driven
// by a shared PWM counter and a shared decay-tick divider.
module led_fader
   import led_pkg::*;
#(
   parameter int NLEDS     = NLEDS_DEFAULT,
   parameter int BW        = BW_DEFAULT,
   parameter int DECAY_DIV = DECAY_DIV_DEFAULT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [NLEDS-1:0] i_led,
   output logic [NLEDS-1:0] o_led,
   output logic             o_active
);

   localparam int DCW = cnt_width(DECAY_DIV);
   localparam logic [DCW-1:0] DLAST = DCW'(DECAY_DIV - 1);

   logic [BW-1:0]    pwm_cnt;
   logic [DCW-1:0]   decay_cnt;
   logic             tick;
   logic [NLEDS-1:0] nonzero;

   assign tick = (decay_cnt == DLAST);

   // pwm_cnt wraps naturally at 2^BW
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pwm_cnt   <= '0;
         decay_cnt <= '0;
         o_active  <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + BW'(1);
         decay_cnt <= tick ? '0 : decay_cnt + DCW'(1);
         o_active  <= |nonzero;
      end
   end

   for (genvar k = 0; k < NLEDS; k++) begin : g_ch
      led_fade_channel #(
         .BW(BW)
      ) u_ch (
         .i_clk     (i_clk),
         .i_reset   (i_reset),
         .i_led_bit (i_led[k]),
         .i_tick    (tick),
         .i_pwm_cnt (pwm_cnt),
         .o_led_bit (o_led[k]),
         .o_nonzero (nonzero[k])
      );
   end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: DECAY_DIV=4 and DECAY_DIV=1 instances,
// per-cycle scoreboard plus hand-counted duty/fade totals.
module tb_led_fader;
   import led_pkg::*;

   localparam int N = 7;

   logic i_clk   = 1'b0;
   logic i_reset = 1'b1;

   always #5 i_clk = ~i_clk;

   led_fader_if #(.NLEDS(N)) s_if ();
   led_fader_if #(.NLEDS(N)) f_if ();

   led_fader #(
      .NLEDS(N), .BW(4), .DECAY_DIV(4)
   ) u_slow (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_led    (s_if.led),
      .o_led    (s_if.o_led),
      .o_active (s_if.active)
   );

   led_fader #(
      .NLEDS(N), .BW(4), .DECAY_DIV(1)
   ) u_fast (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_led    (f_if.led),
      .o_led    (f_if.o_led),
      .o_active (f_if.active)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_s[$];
   logic [7:0] q_f[$];

   logic [3:0] mb[2][N];
   logic [3:0] mp[2];
   int         md[2];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Expected {active, led} after each edge, from the spec behaviour
   always @(posedge i_clk) begin
      logic [N-1:0] lv;
      logic [7:0]   e;
      logic         tk;
      int           dv;
      for (int u = 0; u < 2; u++) begin
         lv = (u == 0) ? s_if.led : f_if.led;
         dv = (u == 0) ? 4 : 1;
         e  = '0;
         if (i_reset) begin
            for (int k = 0; k < N; k++) mb[u][k] = '0;
            mp[u] = '0;
            md[u] = 0;
         end else begin
            for (int k = 0; k < N; k++) begin
               e[k] = mb[u][k] > mp[u];
               if (mb[u][k] != 0) e[7] = 1'b1;
            end
            tk = (md[u] == dv - 1);
            for (int k = 0; k < N; k++) begin
               if (lv[k]) mb[u][k] = 4'd15;
               else if (tk && mb[u][k] != 0)
                  mb[u][k] = mb[u][k] - 4'd1;
            end
            mp[u] = mp[u] + 4'd1;
            md[u] = tk ? 0 : md[u] + 1;
         end
         if (u == 0) q_s.push_back(e);
         else        q_f.push_back(e);
      end
   end

   always @(negedge i_clk) begin
      logic [7:0] e;
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         check("slow_led", 32'(s_if.o_led), 32'(e[6:0]));
         check("slow_act", 32'(s_if.active), 32'(e[7]));
      end
      if (q_f.size() > 0) begin
         e = q_f.pop_front();
         check("fast_led", 32'(f_if.o_led), 32'(e[6:0]));
         check("fast_act", 32'(f_if.active), 32'(e[7]));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   // Leaves the bench at the negedge after the last reset edge
   task automatic do_reset();
      i_reset  = 1'b1;
      s_if.led = '0;
      f_if.led = '0;
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int act_cnt;
      int led_cnt;
      int pos;
      int lowcnt[N];

      s_if.led = '0;
      f_if.led = '0;
      @(negedge i_clk);

      // Reset dominance
      s_if.led = 7'h7F;
      f_if.led = 7'h7F;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("rst_led", 32'(s_if.o_led), 32'd0);
         check("rst_act", 32'(s_if.active), 32'd0);
      end
      i_reset  = 1'b0;
      s_if.led = '0;
      f_if.led = '0;
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("rel_led", 32'(s_if.o_led), 32'd0);
         check("rel_act", 32'(s_if.active), 32'd0);
      end

      // Single pulse and fade
      do_reset();
      i_reset  = 1'b0;
      s_if.led = 7'h01;
      act_cnt  = 0;
      led_cnt  = 0;
      for (int j = 1; j <= 80; j++) begin
         step(1);
         if (j == 1) s_if.led = '0;
         if (s_if.active) act_cnt++;
         if (s_if.o_led[0]) led_cnt++;
      end
      check("fade_act_cycles", 32'(act_cnt), 32'd59);
      check("fade_led0_highs", 32'(led_cnt), 32'd29);

      // Held input: 15/16 duty
      s_if.led = 7'h08;
      step(3);
      led_cnt = 0;
      for (int j = 0; j < 32; j++) begin
         step(1);
         if (s_if.o_led[3]) led_cnt++;
      end
      check("held_led3_highs", 32'(led_cnt), 32'd30);
      s_if.led = '0;
      step(70);

      // Load on the tick cycle while bright[2]=5
      do_reset();
      i_reset  = 1'b0;
      s_if.led = 7'h04;
      step(1);
      s_if.led = '0;
      step(42);
      s_if.led = 7'h04;
      step(1);
      s_if.led = '0;
      act_cnt  = 0;
      for (int j = 0; j < 80; j++) begin
         step(1);
         if (s_if.active) act_cnt++;
      end
      check("collide_act_cycles", 32'(act_cnt), 32'd60);

      // Reset mid-fade
      do_reset();
      i_reset  = 1'b0;
      s_if.led = 7'h55;
      step(1);
      s_if.led = '0;
      step(10);
      i_reset = 1'b1;
      step(1);
      check("midrst_led", 32'(s_if.o_led), 32'd0);
      check("midrst_act", 32'(s_if.active), 32'd0);
      i_reset = 1'b0;
      step(1);
      check("midrst_led1", 32'(s_if.o_led), 32'd0);
      check("midrst_act1", 32'(s_if.active), 32'd0);
      s_if.led = 7'h01;
      step(1);
      s_if.led = '0;
      step(20);

      // Walker with DECAY_DIV=1
      do_reset();
      i_reset = 1'b0;
      for (int k = 0; k < N; k++) lowcnt[k] = 0;
      for (int r = 0; r < 5; r++) begin
         for (int st = 0; st < 12; st++) begin
            pos      = (st < 7) ? st : 12 - st;
            f_if.led = N'(1 << pos);
            step(1);
            if (r > 0 || st > 0)
               check("walk_act", 32'(f_if.active), 32'd1);
            for (int k = 0; k < N; k++)
               if (!f_if.o_led[k]) lowcnt[k]++;
         end
      end
      f_if.led = '0;
      for (int k = 0; k < N; k++)
         check("walk_not_stuck", 32'(lowcnt[k] > 0), 32'd1);
      step(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
